// File: rtl/dcache_4kb.sv
// Single-ported, always-hit 4 KB data memory for the memory stage.
// Each load/store returns its tag with a one-cycle ready pulse on the following cycle.
module dcache_4kb #(
    parameter int ID_W  = 4,
    parameter int DEPTH = 1024
) (
    input  logic            gclk,
    input  logic            grst_n,
    input  logic            memR_i,
    input  logic            memW_i,
    input  logic [ID_W-1:0] ldstID_i,
    input  logic [31:0]     addr_i,
    input  logic [31:0]     Wdata_i,
    output logic [31:0]     Rdata_o,
    output logic [ID_W-1:0] ldstID_o,
    output logic            ready_o
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
        logic [31:0]     data;
    } rsp_t;

    logic [31:0]      mem_q [DEPTH];
    logic [IDX_W-1:0] idx;
    logic             wr_en;
    rsp_t             rsp_d, rsp_q;

    // Word-aligned index; low byte bits and bits above 4 KB are ignored.
    assign idx   = addr_i[IDX_W+1:2];
    assign wr_en = grst_n && memW_i;

    // A store wins over a simultaneous load and echoes its own write data.
    always_comb begin
        rsp_d     = rsp_q;
        rsp_d.vld = 1'b0;
        if (memW_i) begin
            rsp_d.vld  = 1'b1;
            rsp_d.id   = ldstID_i;
            rsp_d.data = Wdata_i;
        end else if (memR_i) begin
            rsp_d.vld  = 1'b1;
            rsp_d.id   = ldstID_i;
            rsp_d.data = mem_q[idx];
        end
    end

    always_ff @(posedge gclk) begin
        if (!grst_n) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    // Storage is deliberately left out of reset so data survives a mid-run reset.
    always_ff @(posedge gclk) begin
        if (wr_en) begin
            mem_q[idx] <= Wdata_i;
        end
    end

    assign Rdata_o  = rsp_q.data;
    assign ldstID_o = rsp_q.id;
    assign ready_o  = rsp_q.vld;
endmodule

// File: tb/tb_dcache_4kb.sv
// Directed self-checking bench for dcache_4kb with hand-computed expectations.
module tb_dcache_4kb;
    logic        gclk = 1'b0;
    logic        grst_n;
    logic        memR, memW;
    logic [3:0]  ldstID;
    logic [31:0] addr, Wdata;
    logic [31:0] Rdata;
    logic [3:0]  ldstID_o;
    logic        ready;

    int checks = 0;
    int errors = 0;

    always #5 gclk = ~gclk;

    dcache_4kb #(.ID_W(4), .DEPTH(1024)) dut (
        .gclk     (gclk),
        .grst_n   (grst_n),
        .memR_i   (memR),
        .memW_i   (memW),
        .ldstID_i (ldstID),
        .addr_i   (addr),
        .Wdata_i  (Wdata),
        .Rdata_o  (Rdata),
        .ldstID_o (ldstID_o),
        .ready_o  (ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge gclk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] id,
                         input logic [31:0] a, input logic [31:0] d);
        memR = r; memW = w; ldstID = id; addr = a; Wdata = d;
    endtask

    task automatic rsp(input string tag, input logic rdy, input logic [3:0] id,
                       input logic [31:0] d);
        chk({tag, ".ready"}, {31'd0, ready}, {31'd0, rdy});
        chk({tag, ".id"}, {28'd0, ldstID_o}, {28'd0, id});
        chk({tag, ".rdata"}, Rdata, d);
    endtask

    initial begin
        grst_n = 1'b0;
        drive(1'b1, 1'b0, 4'd5, 32'd0, 32'd0);
        step();
        step();
        rsp("reset", 1'b0, 4'd0, 32'd0);

        grst_n = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        step();
        rsp("post_reset", 1'b0, 4'd0, 32'd0);

        // Store, store, load, load back-to-back
        drive(1'b0, 1'b1, 4'd1, 32'd40, 32'd9000); step();
        rsp("st1", 1'b1, 4'd1, 32'd9000);
        drive(1'b0, 1'b1, 4'd2, 32'd44, 32'd9001); step();
        rsp("st2", 1'b1, 4'd2, 32'd9001);
        drive(1'b1, 1'b0, 4'd3, 32'd40, 32'd0); step();
        rsp("ld3", 1'b1, 4'd3, 32'd9000);
        drive(1'b1, 1'b0, 4'd4, 32'd44, 32'd0); step();
        rsp("ld4", 1'b1, 4'd4, 32'd9001);
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0); step();
        rsp("idle_hold", 1'b0, 4'd4, 32'd9001);

        // Alias / misaligned address maps to word 0
        drive(1'b0, 1'b1, 4'd5, 32'h0000_1003, 32'hDEAD_BEEF); step();
        rsp("st_alias", 1'b1, 4'd5, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 4'd6, 32'h0000_0000, 32'd0); step();
        rsp("ld_alias", 1'b1, 4'd6, 32'hDEAD_BEEF);

        // Simultaneous read+write acts as store
        drive(1'b1, 1'b1, 4'd7, 32'd8, 32'd5); step();
        rsp("rw_both", 1'b1, 4'd7, 32'd5);
        drive(1'b1, 1'b0, 4'd8, 32'd8, 32'd0); step();
        rsp("ld_rw", 1'b1, 4'd8, 32'd5);

        // Single load then idle: one-cycle pulse, outputs hold
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0); step();
        drive(1'b1, 1'b0, 4'd9, 32'd40, 32'd0); step();
        rsp("ld_gap", 1'b1, 4'd9, 32'd9000);
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0); step();
        rsp("gap1", 1'b0, 4'd9, 32'd9000);
        step();
        rsp("gap2", 1'b0, 4'd9, 32'd9000);

        // Reset mid-stream must block the write and keep stored data
        drive(1'b0, 1'b1, 4'd10, 32'd100, 32'd77); step();
        rsp("st77", 1'b1, 4'd10, 32'd77);
        grst_n = 1'b0;
        drive(1'b0, 1'b1, 4'd12, 32'd100, 32'd1); step();
        rsp("mid_reset", 1'b0, 4'd0, 32'd0);
        grst_n = 1'b1;
        drive(1'b1, 1'b0, 4'd11, 32'd100, 32'd0); step();
        rsp("ld77", 1'b1, 4'd11, 32'd77);
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0); step();
        rsp("final_idle", 1'b0, 4'd11, 32'd77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
